game_controller: RTL and testbench

Frame-synchronous game sequencer for the pong design: it recentres and serves the ball, detects misses, keeps both scores, and ends the match at a target score. It drives `ball_position` through that block's `ckick_in` and `reset_in` inputs, and observes the ball x position once per frame at `vsync_start`. It also exports scores and state to the renderer.

---
 rtl/game_controller_pkg.sv | 28 ++
 rtl/game_controller_frame_delay_counter.sv | 40 ++++
 rtl/game_controller.sv | 157 +++++++++++++++
 tb/tb_game_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_controller_pkg.sv
// game_controller_pkg
//   Shared definitions for the pong game sequencer: state encodings,
//   datapath widths, default screen miss bounds and a score helper.
package game_controller_pkg;

  localparam int POS_W   = 10;  // ball x position width
  localparam int SCORE_W = 4;   // per-player score width
  localparam int FRAME_W = 8;   // frame counter width

  // Default miss bounds for a 640-pixel-wide playfield
  localparam int DEF_LEFT_MISS_X  = 8;
  localparam int DEF_RIGHT_MISS_X = 631;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_KICK       = 3'd2,
    ST_PLAY       = 3'd3,
    ST_SCORED     = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_e;

  // Scores are bounded by the win score, so a plain increment never wraps
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] score);
    return score + 4'd1;
  endfunction

endpackage

// File: rtl/game_controller_frame_delay_counter.sv
// frame_delay_counter
//   Counts vsync_start pulses and flags the limit-th one.
//   Ports:
//     clk         - clock
//     rst         - asynchronous reset, active-high
//     clear       - synchronous clear (wins over counting)
//     vsync_start - one-cycle pulse per frame
//     limit       - number of pulses to count (1..255)
//     expired     - high during the limit-th pulse
//   expired is decoded from the count register and the live pulse so the
//   consumer can change state on the very edge that samples that pulse.
module frame_delay_counter
  import game_controller_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               vsync_start,
  input  logic [FRAME_W-1:0] limit,
  output logic               expired
);

  logic [FRAME_W-1:0] count_r;

  // Frame counter: clear has priority, otherwise count each vsync pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (vsync_start) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = vsync_start & (count_r == (limit - 8'd1));

endmodule

// File: rtl/game_controller.sv
// game_controller
//   Frame-synchronous pong sequencer: serves the ball, detects misses,
//   keeps both scores and ends the match at WIN_SCORE.
//   Ports:
//     clock_in, reset_in (async, active-high)
//     vsync_start_in  - one-cycle frame pulse
//     start_in        - debounced start button level
//     ball_x_pos_in   - ball x from ball_position
//     ckick_out       - serve request to ball_position
//     ball_reset_out  - recentre/hold request to ball_position
//     serve_dir_out   - 0 = toward right paddle, 1 = toward left
//     left_score_out, right_score_out, state_out
//     game_over_out, winner_out (0 = left, 1 = right)
module game_controller
  import game_controller_pkg::*;
#(
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int SCORE_HOLD_FRAMES  = 90,
  parameter int LEFT_MISS_X        = DEF_LEFT_MISS_X,
  parameter int RIGHT_MISS_X       = DEF_RIGHT_MISS_X
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               vsync_start_in,
  input  logic               start_in,
  input  logic [POS_W-1:0]   ball_x_pos_in,
  output logic               ckick_out,
  output logic               ball_reset_out,
  output logic               serve_dir_out,
  output logic [SCORE_W-1:0] left_score_out,
  output logic [SCORE_W-1:0] right_score_out,
  output logic [2:0]         state_out,
  output logic               game_over_out,
  output logic               winner_out
);

  state_e             state_r;
  logic               start_q_r;
  logic               start_edge_s;
  logic               expired_s;
  logic               frame_clear_s;
  logic [FRAME_W-1:0] frame_limit_s;

  assign start_edge_s = start_in & ~start_q_r;
  assign state_out    = state_r;

  // Counter runs only while waiting; any expiry also clears it so the next
  // waiting state starts from zero (this also drops a pulse seen on entry)
  always_comb begin
    frame_clear_s = 1'b1;
    if ((state_r == ST_SERVE_WAIT) || (state_r == ST_SCORED)) begin
      frame_clear_s = expired_s;
    end else begin
      frame_clear_s = 1'b1;
    end
  end

  // Delay length depends on which waiting state is active
  always_comb begin
    frame_limit_s = 8'(SERVE_DELAY_FRAMES);
    if (state_r == ST_SCORED) begin
      frame_limit_s = 8'(SCORE_HOLD_FRAMES);
    end else begin
      frame_limit_s = 8'(SERVE_DELAY_FRAMES);
    end
  end

  frame_delay_counter u_frame_delay (
    .clk         (clock_in),
    .rst         (reset_in),
    .clear       (frame_clear_s),
    .vsync_start (vsync_start_in),
    .limit       (frame_limit_s),
    .expired     (expired_s)
  );

  // Game FSM with all outputs registered alongside the state
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_r         <= ST_IDLE;
      start_q_r       <= 1'b1;  // a button held through reset is not a press
      ckick_out       <= 1'b0;
      ball_reset_out  <= 1'b1;
      serve_dir_out   <= 1'b0;
      left_score_out  <= 4'd0;
      right_score_out <= 4'd0;
      game_over_out   <= 1'b0;
      winner_out      <= 1'b0;
    end else begin
      start_q_r <= start_in;
      case (state_r)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_edge_s) begin
            state_r         <= ST_SERVE_WAIT;
            left_score_out  <= 4'd0;
            right_score_out <= 4'd0;
            serve_dir_out   <= 1'b0;
            ckick_out       <= 1'b0;
            ball_reset_out  <= 1'b1;
            game_over_out   <= 1'b0;
            winner_out      <= 1'b0;
          end
        end
        ST_SERVE_WAIT: begin
          if (expired_s) begin
            state_r        <= ST_KICK;
            ckick_out      <= 1'b1;
            ball_reset_out <= 1'b0;
          end
        end
        ST_KICK: begin
          // Holding the kick until the next frame pulse guarantees the
          // ball block sees it on at least one frame update
          if (vsync_start_in) begin
            state_r   <= ST_PLAY;
            ckick_out <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (vsync_start_in) begin
            if (ball_x_pos_in <= 10'(LEFT_MISS_X)) begin
              state_r         <= ST_SCORED;
              right_score_out <= score_inc(right_score_out);
              serve_dir_out   <= 1'b1;
              ball_reset_out  <= 1'b1;
            end else if (ball_x_pos_in >= 10'(RIGHT_MISS_X)) begin
              state_r        <= ST_SCORED;
              left_score_out <= score_inc(left_score_out);
              serve_dir_out  <= 1'b0;
              ball_reset_out <= 1'b1;
            end
          end
        end
        ST_SCORED: begin
          if (expired_s) begin
            if ((left_score_out == 4'(WIN_SCORE)) || (right_score_out == 4'(WIN_SCORE))) begin
              state_r       <= ST_GAME_OVER;
              game_over_out <= 1'b1;
              winner_out    <= (right_score_out == 4'(WIN_SCORE));
            end else begin
              state_r <= ST_SERVE_WAIT;
            end
          end
        end
        default: begin
          // Unused codes fall back to a clean idle
          state_r        <= ST_IDLE;
          ckick_out      <= 1'b0;
          ball_reset_out <= 1'b1;
          game_over_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller
//   Directed bench for game_controller with a small expectation queue:
//   expectations are queued as stimulus is applied and drained against the
//   DUT outputs once the relevant clock edge has happened.
module tb_game_controller;

  localparam int S_STATE = 0;
  localparam int S_CKICK = 1;
  localparam int S_BRST  = 2;
  localparam int S_DIR   = 3;
  localparam int S_LS    = 4;
  localparam int S_RS    = 5;
  localparam int S_GO    = 6;
  localparam int S_WIN   = 7;

  typedef struct {
    string tag;
    int    sig;
    int    val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_in;
  logic       vsync;
  logic       start;
  logic [9:0] ball_x;
  logic       ckick;
  logic       ball_reset;
  logic       serve_dir;
  logic [3:0] left_score;
  logic [3:0] right_score;
  logic [2:0] state;
  logic       game_over;
  logic       winner;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  game_controller #(
    .WIN_SCORE          (2),
    .SERVE_DELAY_FRAMES (2),
    .SCORE_HOLD_FRAMES  (3)
  ) dut (
    .clock_in        (clk),
    .reset_in        (reset_in),
    .vsync_start_in  (vsync),
    .start_in        (start),
    .ball_x_pos_in   (ball_x),
    .ckick_out       (ckick),
    .ball_reset_out  (ball_reset),
    .serve_dir_out   (serve_dir),
    .left_score_out  (left_score),
    .right_score_out (right_score),
    .state_out       (state),
    .game_over_out   (game_over),
    .winner_out      (winner)
  );

  always #5 clk = ~clk;

  function automatic void expect_sig(input string tag, input int sig, input int val);
    sb.push_back('{tag, sig, val});
  endfunction

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_STATE: return {29'd0, state};
      S_CKICK: return {31'd0, ckick};
      S_BRST:  return {31'd0, ball_reset};
      S_DIR:   return {31'd0, serve_dir};
      S_LS:    return {28'd0, left_score};
      S_RS:    return {28'd0, right_score};
      S_GO:    return {31'd0, game_over};
      S_WIN:   return {31'd0, winner};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      total++;
      assert (o === 32'(e.val)) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", e.tag, o, e.val);
    end
  endtask

  // 19 quiet clocks then one vsync cycle; returns just after the edge that
  // sampled the pulse
  task automatic frame(input logic [9:0] x_mid, input logic [9:0] x_pulse);
    ball_x = x_mid;
    repeat (19) @(negedge clk);
    ball_x = x_pulse;
    vsync  = 1'b1;
    @(negedge clk);
    vsync  = 1'b0;
    ball_x = x_mid;
  endtask

  initial begin
    reset_in = 1'b1;
    vsync    = 1'b0;
    start    = 1'b1;
    ball_x   = 10'd300;

    // Reset held with start pressed
    repeat (50) @(negedge clk);
    expect_sig("rst_state", S_STATE, 0);
    expect_sig("rst_ckick", S_CKICK, 0);
    expect_sig("rst_brst",  S_BRST,  1);
    expect_sig("rst_dir",   S_DIR,   0);
    expect_sig("rst_ls",    S_LS,    0);
    expect_sig("rst_rs",    S_RS,    0);
    expect_sig("rst_go",    S_GO,    0);
    expect_sig("rst_win",   S_WIN,   0);
    drain();

    // Button still held after reset release: no start
    reset_in = 1'b0;
    repeat (3) @(negedge clk);
    expect_sig("held_state", S_STATE, 0);
    expect_sig("held_brst",  S_BRST,  1);
    drain();

    // Release, then press together with a vsync pulse (pulse must not count)
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
    start = 1'b0;
    expect_sig("start_state", S_STATE, 1);
    drain();

    frame(10'd300, 10'd300);
    expect_sig("sw1_state", S_STATE, 1);
    expect_sig("sw1_ckick", S_CKICK, 0);
    drain();
    frame(10'd300, 10'd300);
    expect_sig("kick_state", S_STATE, 2);
    expect_sig("kick_ckick", S_CKICK, 1);
    expect_sig("kick_brst",  S_BRST,  0);
    expect_sig("kick_dir",   S_DIR,   0);
    drain();
    repeat (10) @(negedge clk);
    expect_sig("kick_mid_ckick", S_CKICK, 1);
    drain();
    frame(10'd300, 10'd300);
    expect_sig("play_state", S_STATE, 3);
    expect_sig("play_ckick", S_CKICK, 0);
    expect_sig("play_brst",  S_BRST,  0);
    drain();

    // Left miss
    frame(10'd300, 10'd5);
    expect_sig("miss1_state", S_STATE, 4);
    expect_sig("miss1_rs",    S_RS,    1);
    expect_sig("miss1_ls",    S_LS,    0);
    expect_sig("miss1_dir",   S_DIR,   1);
    expect_sig("miss1_brst",  S_BRST,  1);
    drain();
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    expect_sig("hold2_state", S_STATE, 4);
    drain();
    frame(10'd300, 10'd300);
    expect_sig("hold3_state", S_STATE, 1);
    drain();

    // Second serve
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    expect_sig("kick2_state", S_STATE, 2);
    expect_sig("kick2_dir",   S_DIR,   1);
    drain();
    frame(10'd300, 10'd300);
    expect_sig("play2_state", S_STATE, 3);
    drain();

    // Miss positions between pulses are ignored; x=9 is just inside
    frame(10'd631, 10'd300);
    expect_sig("between_state", S_STATE, 3);
    expect_sig("between_rs",    S_RS,    1);
    expect_sig("between_ls",    S_LS,    0);
    drain();
    frame(10'd0, 10'd9);
    expect_sig("x9_state", S_STATE, 3);
    expect_sig("x9_rs",    S_RS,    1);
    drain();

    // x=8 exactly is a left miss and reaches the win score
    frame(10'd300, 10'd8);
    expect_sig("miss2_state", S_STATE, 4);
    expect_sig("miss2_rs",    S_RS,    2);
    expect_sig("miss2_go",    S_GO,    0);
    drain();
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    expect_sig("over_state", S_STATE, 5);
    expect_sig("over_go",    S_GO,    1);
    expect_sig("over_win",   S_WIN,   1);
    expect_sig("over_ls",    S_LS,    0);
    expect_sig("over_rs",    S_RS,    2);
    expect_sig("over_brst",  S_BRST,  1);
    drain();
    frame(10'd300, 10'd631);
    expect_sig("over_hold_state", S_STATE, 5);
    expect_sig("over_hold_ls",    S_LS,    0);
    drain();

    // Restart from GAME_OVER
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_sig("restart_state", S_STATE, 1);
    expect_sig("restart_rs",    S_RS,    0);
    expect_sig("restart_ls",    S_LS,    0);
    expect_sig("restart_go",    S_GO,    0);
    expect_sig("restart_dir",   S_DIR,   0);
    drain();

    // Right miss at exactly 631 scores for the left player
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    expect_sig("play3_state", S_STATE, 3);
    drain();
    frame(10'd300, 10'd631);
    expect_sig("rmiss_state", S_STATE, 4);
    expect_sig("rmiss_ls",    S_LS,    1);
    expect_sig("rmiss_rs",    S_RS,    0);
    expect_sig("rmiss_dir",   S_DIR,   0);
    drain();
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    frame(10'd300, 10'd300);
    expect_sig("kick3_state", S_STATE, 2);
    expect_sig("kick3_ckick", S_CKICK, 1);
    drain();

    // Asynchronous reset in the middle of KICK
    repeat (5) @(negedge clk);
    #2;
    reset_in = 1'b1;
    #1;
    expect_sig("arst_ckick", S_CKICK, 0);
    expect_sig("arst_state", S_STATE, 0);
    expect_sig("arst_ls",    S_LS,    0);
    expect_sig("arst_brst",  S_BRST,  1);
    drain();
    @(negedge clk);
    reset_in = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
